// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared opcode, state and width definitions for the ALU execute stage
package alu_exec_pkg;

  localparam int ALU_OP_W   = 4;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_XOR = 4'b0000,
    ALU_SLL = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_SRA = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_OR  = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - one-bit-per-cycle shifter with start/done handshake
module alu_shift_iter
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic            left_i,
  input  logic            arith_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  shift_state_e    state_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] sreg_q;
  logic            left_q;
  logic            arith_q;
  logic [XLEN-1:0] shift_one;

  // Single-bit step; right shifts fill with the sign bit only for SRA
  always_comb begin
    shift_one = '0;
    if (left_q) begin
      shift_one = {sreg_q[XLEN-2:0], 1'b0};
    end else begin
      shift_one = {arith_q & sreg_q[XLEN-1], sreg_q[XLEN-1:1]};
    end
  end

  // Control FSM plus datapath; start is only honoured when not shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SH_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= SH_IDLE;
    end else begin
      case (state_q)
        SH_SHIFT: begin
          sreg_q <= shift_one;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state_q <= SH_DONE;
          end
        end
        default: begin
          if (start_i) begin
            state_q <= SH_SHIFT;
            cnt_q   <= shamt_i;
            sreg_q  <= data_i;
            left_q  <= left_i;
            arith_q <= arith_i;
          end else begin
            state_q <= SH_IDLE;
          end
        end
      endcase
    end
  end

  // The last step's value goes straight into the output slot on the edge entering DONE
  assign busy_o   = (state_q == SH_SHIFT);
  assign done_o   = (state_q == SH_SHIFT) && (cnt_q == SHW'(1));
  assign result_o = shift_one;

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with registered one-entry output slot (option: ALU_EXEC_ITER_SHIFT_EN)
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_W-1:0]   alucontrol,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  branch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  zero,
  output logic                  branch_taken,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write
);

  logic [SHW-1:0]        shamt;
  logic [XLEN-1:0]       alu_res;
  logic                  accept;
  logic                  busy;
  logic                  start_iter;

  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  br_q, br_d;

  assign shamt    = operand_b[SHW-1:0];
  assign in_ready = !busy && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Combinational ALU; unlisted codes fall through to zero
  always_comb begin
    alu_res = '0;
    case (alucontrol)
      ALU_XOR: alu_res = operand_a ^ operand_b;
      ALU_ADD: alu_res = operand_a + operand_b;
      ALU_AND: alu_res = operand_a & operand_b;
      ALU_SUB: alu_res = operand_a - operand_b;
      ALU_OR:  alu_res = operand_a | operand_b;
`ifdef ALU_EXEC_ITER_SHIFT_EN
      // Only reaches the slot when shamt is zero; otherwise the iterative shifter owns it
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = operand_a;
`else
      ALU_SLL: alu_res = operand_a << shamt;
      ALU_SRL: alu_res = operand_a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(operand_a) >>> shamt);
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_ITER_SHIFT_EN
  logic                  is_shift;
  logic                  iter_done;
  logic [XLEN-1:0]       iter_res;
  logic [REG_ADDR_W-1:0] pend_rd_q;
  logic                  pend_rw_q;
  logic                  pend_br_q;

  assign is_shift   = (alucontrol == ALU_SLL) || (alucontrol == ALU_SRL) || (alucontrol == ALU_SRA);
  assign start_iter = accept && is_shift && (shamt != '0);

  alu_shift_iter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shift_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .start_i  (start_iter),
    .left_i   (alucontrol == ALU_SLL),
    .arith_i  (alucontrol == ALU_SRA),
    .data_i   (operand_a),
    .shamt_i  (shamt),
    .busy_o   (busy),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  // Sideband of the operation being shifted, held until the shifter finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rd_q <= '0;
      pend_rw_q <= 1'b0;
      pend_br_q <= 1'b0;
    end else if (start_iter) begin
      pend_rd_q <= rd_addr;
      pend_rw_q <= reg_write;
      pend_br_q <= branch;
    end
  end
`else
  assign start_iter = 1'b0;
  assign busy       = 1'b0;
`endif

  // Slot next state: flush wins, then a fresh result, then draining
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    br_d        = br_q;
    if (flush) begin
      out_valid_d = 1'b0;
      rw_d        = 1'b0;
      br_d        = 1'b0;
    end else if (accept && !start_iter) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      rd_d        = rd_addr;
      rw_d        = reg_write;
      br_d        = branch;
`ifdef ALU_EXEC_ITER_SHIFT_EN
    end else if (iter_done) begin
      out_valid_d = 1'b1;
      result_d    = iter_res;
      rd_d        = pend_rd_q;
      rw_d        = pend_rw_q;
      br_d        = pend_br_q;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      br_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      br_q        <= br_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign zero          = (result_q == '0);
  assign branch_taken  = br_q && zero;
  assign out_rd_addr   = rd_q;
  assign out_reg_write = rw_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

`ifdef ALU_EXEC_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alucontrol = 4'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  rd_addr = '0;
  logic        reg_write = 1'b0;
  logic        branch = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: slot contents plus remaining shift cycles
  logic        m_valid = 1'b0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;
  logic        m_rw = 1'b0;
  logic        m_br = 1'b0;
  int          m_busy = 0;
  logic [31:0] p_res = '0;
  logic [4:0]  p_rd = '0;
  logic        p_rw = 1'b0;
  logic        p_br = 1'b0;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alucontrol    (alucontrol),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .rd_addr       (rd_addr),
    .reg_write     (reg_write),
    .branch        (branch),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .branch_taken  (branch_taken),
    .out_rd_addr   (out_rd_addr),
    .out_reg_write (out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh = b % 32;
    case (op)
      4'd0: return a ^ b;
      4'd1: return a << sh;
      4'd2: return a + b;
      4'd3: return a & b;
      4'd4: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd5: return a >> sh;
      4'd6: return a - b;
      4'd8: return a | b;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one cycle of inputs, compare against the model, advance the model across the edge
  task automatic cycle(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw, input logic br, input logic ordy, input logic fl);
    logic exp_rdy;
    logic acc;
    logic cons;
    int   sh;
    in_valid = v; alucontrol = op; operand_a = a; operand_b = b;
    rd_addr = rd; reg_write = rw; branch = br; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (m_busy == 0) && (!m_valid || ordy) && !fl;
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check_eq("result", result, m_res);
      check_eq("zero", zero, m_res == 0);
      check_eq("branch_taken", branch_taken, m_br && (m_res == 0));
      check_eq("out_rd_addr", out_rd_addr, m_rd);
      check_eq("out_reg_write", out_reg_write, m_rw);
    end
    acc  = v && exp_rdy;
    cons = m_valid && ordy;
    sh   = int'(b[4:0]);
    if (fl) begin
      m_valid = 1'b0; m_busy = 0; m_rw = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1; m_res = p_res; m_rd = p_rd; m_rw = p_rw; m_br = p_br;
      end
    end else if (acc && ITER && (op == 4'd1 || op == 4'd4 || op == 4'd5) && sh != 0) begin
      m_busy = sh; p_res = ref_alu(op, a, b); p_rd = rd; p_rw = rw; p_br = br;
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_res = ref_alu(op, a, b); m_rd = rd; m_rw = rw; m_br = br;
    end else if (cons) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // Issue one op into a draining slot, wait for its result, check it against a constant
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input logic [31:0] exp_res, input logic exp_bt, input int exp_lat);
    int lat = 1;
    cycle(1'b1, op, a, b, 5'd7, 1'b1, br, 1'b1, 1'b0);
    while (!out_valid && lat < 40) begin
      if (ITER && lat == 1) check_eq({tag, "_busy_ready"}, in_ready, 1'b0);
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_zero"}, zero, exp_res == 0);
    check_eq({tag, "_bt"}, branch_taken, exp_bt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_zero", zero, 1'b1);
    check_eq("rst_branch_taken", branch_taken, 1'b0);
    check_eq("rst_out_reg_write", out_reg_write, 1'b0);
    check_eq("rst_out_rd_addr", out_rd_addr, 5'd0);
    check_eq("rst_result", result, 32'd0);
    m_valid = 1'b0; m_res = '0; m_rd = '0; m_rw = 1'b0; m_br = 1'b0; m_busy = 0;
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    #1;
    do_reset();
    idle(1'b1);

    run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0, 1);
    run_op("sub", 4'd6, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("and", 4'd3, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 32'h0000_00F0, 1'b0, 1);
    run_op("or", 4'd8, 32'h0000_1200, 32'h0000_0034, 1'b0, 32'h0000_1234, 1'b0, 1);
    run_op("xor", 4'd0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 32'h0000_F0F0, 1'b0, 1);
    run_op("illegal", 4'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'd0, 1'b0, 1);
    run_op("sra", 4'd4, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000, 1'b0, ITER ? 5 : 1);
    run_op("srl", 4'd5, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000, 1'b0, ITER ? 5 : 1);
    run_op("sll", 4'd1, 32'd1, 32'h21, 1'b0, 32'd2, 1'b0, ITER ? 2 : 1);
    run_op("sll0", 4'd1, 32'h55, 32'h20, 1'b0, 32'h55, 1'b0, 1);
    run_op("beq_eq", 4'd6, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 1);
    run_op("beq_ne", 4'd6, 32'd9, 32'd8, 1'b1, 32'd1, 1'b0, 1);
    run_op("nobr_zero", 4'd3, 32'd0, 32'd5, 1'b0, 32'd0, 1'b0, 1);
    idle(1'b1);

    // Backpressure: slot held for three cycles while a second op waits
    cycle(1'b1, 4'd2, 32'd10, 32'd20, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    held = result;
    check_eq("bp_first", held, 32'd30);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'd6, 32'd100, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("bp_hold", result, held);
    end
    cycle(1'b1, 4'd6, 32'd100, 32'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("bp_second", result, 32'd99);
    idle(1'b1);

    // Flush with a full slot and a pending input
    cycle(1'b1, 4'd2, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 4'd0, 32'd6, 32'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_rw", out_reg_write, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush shortly after a long shift is accepted
    cycle(1'b1, 4'd1, 32'd1, 32'd8, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("flush2_valid", out_valid, 1'b0);
    check_eq("flush2_rw", out_reg_write, 1'b0);
    for (int i = 0; i < 12; i++) idle(1'b1);

    // Reset with an operation in the slot
    cycle(1'b1, 4'd2, 32'd3, 32'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? rb : $urandom, rb,
            5'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 40; i++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
